// File: rtl/wrf_frame_monitor.sv
// wrf_frame_monitor: transparent WR-fabric tap that measures frame statistics.
//
// Passes the decoder-to-fabric stream through combinationally and records the
// frame count, last/min/max length, runts, longest back-pressure run and
// (optionally) inter-frame gap. Software reads them over a pipelined Wishbone
// slave.
//
// Optional feature macro: WRF_MON_GAP_EN adds the inter-frame gap counter
// (GAP_LAST at 0x18, GAP_MIN at 0x1C). Without it those offsets read 0.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   snk_*                   fabric input from the decoder; snk_ack/snk_stall back
//   src_*                   fabric output to the sink; src_ack/src_stall in
//   wb_*                    32-bit register slave (wb_adr[4:2] decoded, wb_sel ignored)
module wrf_frame_monitor #(
  parameter int unsigned g_min_len   = 60,
  parameter logic [15:0] g_stall_sat = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        snk_cyc,
  input  logic        snk_stb,
  input  logic        snk_we,
  input  logic [1:0]  snk_adr,
  input  logic [1:0]  snk_sel,
  input  logic [15:0] snk_dat,
  output logic        snk_ack,
  output logic        snk_stall,
  output logic        src_cyc,
  output logic        src_stb,
  output logic        src_we,
  output logic [1:0]  src_adr,
  output logic [1:0]  src_sel,
  output logic [15:0] src_dat,
  input  logic        src_ack,
  input  logic        src_stall,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_stall
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_FRAMES    = 3'd1;
  localparam logic [2:0] REG_LAST_LEN  = 3'd2;
  localparam logic [2:0] REG_MINMAX    = 3'd3;
  localparam logic [2:0] REG_RUNTS     = 3'd4;
  localparam logic [2:0] REG_STALL_MAX = 3'd5;
  localparam logic [2:0] REG_GAP_LAST  = 3'd6;
  localparam logic [2:0] REG_GAP_MIN   = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

  // Transparent pass-through in both directions.
  assign src_cyc   = snk_cyc;
  assign src_stb   = snk_stb;
  assign src_we    = snk_we;
  assign src_adr   = snk_adr;
  assign src_sel   = snk_sel;
  assign src_dat   = snk_dat;
  assign snk_ack   = src_ack;
  assign snk_stall = src_stall;
  assign wb_stall  = 1'b0;

  logic             cyc_q;
  logic             cyc_rise_c;
  logic             beat_acc_c;
  logic [1:0]       beat_bytes_c;
  frame_state_t     state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt, len_base_c, len_sat_c;
  logic [LEN_W:0]   len_sum_c;
  logic             frame_end_c;
  logic [LEN_W-1:0] stall_run;
  logic             stall_c, stall_end_c;
  logic [CNT_W-1:0] frames, runts;
  logic [LEN_W-1:0] last_len, min_len, max_len, stall_max;
  logic             req_c, mapped_c, wr_ctrl_c;
  logic             freeze_q, clr_q;
  logic [31:0]      rd_data_c;
  logic             unused_bits;

  assign unused_bits = ^{wb_sel, wb_adr[1:0], wb_dat_i[31:2]};

  // cyc history is deliberately not reset: it keeps following the bus during
  // reset, so a frame already open at reset release shows no rising edge.
  always_ff @(posedge clk_i) begin
    cyc_q <= snk_cyc;
  end

  assign cyc_rise_c = snk_cyc & ~cyc_q;
  assign beat_acc_c = snk_cyc & snk_stb & ~src_stall;

  // Bytes carried by the current beat: only accepted data-address beats count.
  always_comb begin
    beat_bytes_c = 2'd0;
    if (beat_acc_c && snk_adr == 2'b00) begin
      if (snk_sel == 2'b11)      beat_bytes_c = 2'd2;
      else if (snk_sel == 2'b10) beat_bytes_c = 2'd1;
    end
  end

  // Frame tracker state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      len   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
    end
  end

  // Frame tracker next state; the rising cycle may already carry a beat.
  always_comb begin
    state_nxt   = state;
    len_nxt     = len;
    frame_end_c = 1'b0;
    len_base_c  = (state == ST_IDLE) ? '0 : len;
    len_sum_c   = (LEN_W+1)'(len_base_c) + (LEN_W+1)'(beat_bytes_c);
    len_sat_c   = len_sum_c[LEN_W] ? '1 : len_sum_c[LEN_W-1:0];
    unique case (state)
      ST_IDLE: begin
        if (cyc_rise_c) begin
          state_nxt = ST_IN_FRAME;
          len_nxt   = len_sat_c;
        end
      end
      ST_IN_FRAME: begin
        if (!snk_cyc) begin
          state_nxt   = ST_IDLE;
          frame_end_c = 1'b1;
        end else begin
          len_nxt = len_sat_c;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Back-pressure run tracker.
  assign stall_c     = snk_cyc & snk_stb & src_stall;
  assign stall_end_c = ~stall_c & (stall_run != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_run <= '0;
    end else if (stall_c) begin
      stall_run <= (stall_run == g_stall_sat) ? stall_run : stall_run + LEN_W'(1);
    end else begin
      stall_run <= '0;
    end
  end

  // Statistics: CLR beats a coinciding frame end; FREEZE drops outcomes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frames    <= '0;
      last_len  <= '0;
      min_len   <= '1;
      max_len   <= '0;
      runts     <= '0;
      stall_max <= '0;
    end else if (clr_q) begin
      frames    <= '0;
      last_len  <= '0;
      min_len   <= '1;
      max_len   <= '0;
      runts     <= '0;
      stall_max <= '0;
    end else if (!freeze_q) begin
      if (frame_end_c) begin
        frames   <= frames + CNT_W'(1);
        last_len <= len;
        if (len < min_len) min_len <= len;
        if (len > max_len) max_len <= len;
        if (CNT_W'(len) < g_min_len) runts <= runts + CNT_W'(1);
      end
      if (stall_end_c && stall_run > stall_max) stall_max <= stall_run;
    end
  end

`ifdef WRF_MON_GAP_EN
  logic [CNT_W-1:0] gap_cnt, gap_last, gap_min;
  logic             have_prev;

  // Idle-cycle counter and gap capture on the next frame start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gap_cnt   <= '0;
      gap_last  <= '0;
      gap_min   <= '1;
      have_prev <= 1'b0;
    end else begin
      if (snk_cyc)               gap_cnt <= '0;
      else if (gap_cnt != '1)    gap_cnt <= gap_cnt + CNT_W'(1);
      if (clr_q) begin
        gap_last  <= '0;
        gap_min   <= '1;
        have_prev <= 1'b0;
      end else begin
        if (frame_end_c) have_prev <= 1'b1;
        if (!freeze_q && cyc_rise_c && have_prev) begin
          gap_last <= gap_cnt;
          if (gap_cnt < gap_min) gap_min <= gap_cnt;
        end
      end
    end
  end
`endif

  // Register decode; anything above 0x1C is unmapped.
  assign req_c     = wb_cyc & wb_stb;
  assign mapped_c  = (wb_adr[31:5] == '0);
  assign wr_ctrl_c = req_c & wb_we & mapped_c & (wb_adr[4:2] == REG_CTRL);

  always_comb begin
    rd_data_c = '0;
    if (mapped_c) begin
      case (wb_adr[4:2])
        REG_CTRL:      rd_data_c = {30'd0, freeze_q, 1'b0};
        REG_FRAMES:    rd_data_c = frames;
        REG_LAST_LEN:  rd_data_c = 32'(last_len);
        REG_MINMAX:    rd_data_c = {max_len, min_len};
        REG_RUNTS:     rd_data_c = runts;
        REG_STALL_MAX: rd_data_c = 32'(stall_max);
`ifdef WRF_MON_GAP_EN
        REG_GAP_LAST:  rd_data_c = gap_last;
        REG_GAP_MIN:   rd_data_c = gap_min;
`endif
        default:       rd_data_c = '0;
      endcase
    end
  end

  // Single-cycle ack; CLR is a one-cycle pulse applied on the following edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      freeze_q <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      wb_ack   <= req_c;
      wb_dat_o <= (req_c && !wb_we) ? rd_data_c : '0;
      clr_q    <= wr_ctrl_c & wb_dat_i[0];
      if (wr_ctrl_c) freeze_q <= wb_dat_i[1];
    end
  end

endmodule

// File: tb/tb_wrf_frame_monitor.sv
// Self-checking bench for wrf_frame_monitor: directed steps with randomized
// frame lengths, stall patterns and fabric data, checked against a
// frame-list reference model.
module tb_wrf_frame_monitor;

  localparam int MIN_LEN = 60;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        snk_cyc = 1'b0, snk_stb = 1'b0, snk_we = 1'b0;
  logic [1:0]  snk_adr = '0, snk_sel = '0;
  logic [15:0] snk_dat = '0;
  logic        snk_ack, snk_stall;
  logic        src_cyc, src_stb, src_we;
  logic [1:0]  src_adr, src_sel;
  logic [15:0] src_dat;
  logic        src_ack = 1'b0, src_stall = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack, wb_stall;

  wrf_frame_monitor dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .snk_cyc(snk_cyc), .snk_stb(snk_stb), .snk_we(snk_we),
    .snk_adr(snk_adr), .snk_sel(snk_sel), .snk_dat(snk_dat),
    .snk_ack(snk_ack), .snk_stall(snk_stall),
    .src_cyc(src_cyc), .src_stb(src_stb), .src_we(src_we),
    .src_adr(src_adr), .src_sel(src_sel), .src_dat(src_dat),
    .src_ack(src_ack), .src_stall(src_stall),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .wb_stall(wb_stall)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int snk_beats = 0, src_beats = 0, sent_beats = 0;
  int stall_q[$];
  int m_frames[$];
  int m_stall_max = 0;
  bit m_frozen = 1'b0;

  always @(posedge clk_i) begin
    if (snk_cyc && snk_stb && !snk_stall) snk_beats <= snk_beats + 1;
    if (src_cyc && src_stb && !src_stall) src_beats <= src_beats + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: statistics derived from the list of recorded frame lengths.
  function automatic logic [31:0] e_last();
    return (m_frames.size() > 0) ? 32'(m_frames[m_frames.size()-1]) : 32'd0;
  endfunction

  function automatic logic [31:0] e_minmax();
    int mn = 16'hFFFF;
    int mx = 0;
    foreach (m_frames[i]) begin
      if (m_frames[i] < mn) mn = m_frames[i];
      if (m_frames[i] > mx) mx = m_frames[i];
    end
    return {16'(mx), 16'(mn)};
  endfunction

  function automatic logic [31:0] e_runts();
    int n = 0;
    foreach (m_frames[i]) if (m_frames[i] < MIN_LEN) n++;
    return 32'(n);
  endfunction

  task automatic drive_fab(input logic cyc, input logic stb, input logic [1:0] adr,
                           input logic [1:0] sel, input logic stall);
    snk_cyc   = cyc;
    snk_stb   = stb;
    snk_adr   = adr;
    snk_sel   = sel;
    snk_dat   = 16'($urandom);
    snk_we    = 1'($urandom);
    src_ack   = 1'($urandom);
    src_stall = stall;
    #1;
    chk("passthru",
        32'({src_cyc, src_stb, src_we, src_adr, src_sel, src_dat, snk_ack, snk_stall}),
        32'({snk_cyc, snk_stb, snk_we, snk_adr, snk_sel, snk_dat, src_ack, src_stall}));
  endtask

  task automatic send_beat(input logic [1:0] adr, input logic [1:0] sel, input bit with_clr);
    int n;
    n = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
    repeat (n) begin
      @(negedge clk_i);
      drive_fab(1'b1, 1'b1, adr, sel, 1'b1);
    end
    @(negedge clk_i);
    if (with_clr) begin
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h0; wb_dat_i = 32'h1;
    end
    drive_fab(1'b1, 1'b1, adr, sel, 1'b0);
    if (!m_frozen && n > m_stall_max) m_stall_max = n;
    sent_beats++;
  endtask

  task automatic send_frame(input int nbytes, input bit status, input bit clr_end);
    int rem;
    int nb;
    rem = nbytes;
    nb  = (nbytes + 1) / 2;
    @(negedge clk_i);
    drive_fab(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    if (status) send_beat(2'b01, 2'b11, 1'b0);
    for (int b = 0; b < nb; b++) begin
      send_beat(2'b00, (rem >= 2) ? 2'b11 : 2'b10, clr_end && (b == nb - 1));
      rem -= 2;
    end
    @(negedge clk_i);
    drive_fab(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    if (clr_end) begin
      chk("clr_ack", 32'(wb_ack), 32'd1);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      m_frames.delete();
      m_stall_max = 0;
    end else if (!m_frozen) begin
      m_frames.push_back(nbytes);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk_i);
      drive_fab(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    @(negedge clk_i);
    chk("ack_pre", 32'(wb_ack), 32'd0);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat;
    wb_sel = 4'($urandom);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("ack", 32'(wb_ack), 32'd1);
    rdat = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    wb_access(1'b0, adr, 32'h0, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] d;
    wb_access(1'b1, adr, wdat, d);
  endtask

  task automatic check_stats();
    rd_chk(32'h04, 32'(m_frames.size()), "FRAMES");
    rd_chk(32'h08, e_last(), "LAST_LEN");
    rd_chk(32'h0C, e_minmax(), "MINMAX");
    rd_chk(32'h10, e_runts(), "RUNTS");
    rd_chk(32'h14, 32'(m_stall_max), "STALL_MAX");
`ifndef WRF_MON_GAP_EN
    rd_chk(32'h18, 32'h0, "GAP_LAST_off");
    rd_chk(32'h1C, 32'h0, "GAP_MIN_off");
`endif
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("wb_stall", 32'(wb_stall), 32'd0);
    rst_n_i = 1'b1;
    rd_chk(32'h00, 32'h0, "CTRL_rst");
    check_stats();
`ifdef WRF_MON_GAP_EN
    rd_chk(32'h18, 32'h0, "GAP_LAST_rst");
    rd_chk(32'h1C, 32'hFFFF_FFFF, "GAP_MIN_rst");
`endif

    // 64, 1500, 61 byte frames with no back-pressure.
    send_frame(64, 1'b0, 1'b0);
    send_frame(1500, 1'b0, 1'b0);
    send_frame(61, 1'b0, 1'b0);
    rd_chk(32'h04, 32'd3, "FRAMES_tp1");
    rd_chk(32'h08, 32'd61, "LAST_tp1");
    rd_chk(32'h0C, 32'h05DC_003D, "MINMAX_tp1");
    rd_chk(32'h10, 32'd0, "RUNTS_tp1");

    // Runt and empty frame.
    send_frame(40, 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0);
    rd_chk(32'h10, 32'd2, "RUNTS_tp2");
    rd_chk(32'h0C, 32'h05DC_0000, "MINMAX_tp2");

    // Back-to-back reads acked on consecutive cycles.
    @(negedge clk_i);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h04;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("b2b_ack0", 32'(wb_ack), 32'd1);
    chk("b2b_dat0", wb_dat_o, 32'd5);
    wb_adr = 32'h10;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("b2b_ack1", 32'(wb_ack), 32'd1);
    chk("b2b_dat1", wb_dat_o, 32'd2);
    wb_cyc = 1'b0; wb_stb = 1'b0;

    // Stall runs of 7 and 3 inside one frame.
    stall_q = '{7, 0, 0, 3};
    send_frame(20, 1'b0, 1'b0);
    rd_chk(32'h14, 32'd7, "STALL_MAX_tp3");
    chk("beats_snk_src", 32'(src_beats), 32'(snk_beats));
    chk("beats_sent", 32'(src_beats), 32'(sent_beats));

    // Randomized frames with random stalls and non-data beats.
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(0, 200);
      stall_q.delete();
      for (int b = 0; b < 110; b++)
        stall_q.push_back(($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : 0);
      send_frame(len, 1'($urandom), 1'b0);
      if (f % 4 == 3) idle($urandom_range(0, 6));
    end
    stall_q.delete();
    check_stats();

    // FREEZE: outcomes while frozen are discarded.
    wr(32'h00, 32'h2);
    rd_chk(32'h00, 32'h2, "CTRL_freeze");
    m_frozen = 1'b1;
    stall_q = '{12};
    for (int f = 0; f < 5; f++) send_frame($urandom_range(0, 120), 1'b0, 1'b0);
    wr(32'h00, 32'h0);
    m_frozen = 1'b0;
    check_stats();

    // CLR landing on the frame-end update cycle.
    stall_q.delete();
    send_frame(20, 1'b0, 1'b1);
    rd_chk(32'h04, 32'd0, "FRAMES_clr");
    rd_chk(32'h0C, 32'h0000_FFFF, "MINMAX_clr");
    rd_chk(32'h00, 32'h0, "CTRL_clr");
    check_stats();

`ifdef WRF_MON_GAP_EN
    // Gaps of 100 then 20 idle cycles.
    send_frame(64, 1'b0, 1'b0);
    idle(99);
    send_frame(30, 1'b0, 1'b0);
    idle(19);
    send_frame(50, 1'b0, 1'b0);
    rd_chk(32'h18, 32'd20, "GAP_LAST");
    rd_chk(32'h1C, 32'd20, "GAP_MIN");
    check_stats();
`endif

    // Reset asserted mid-frame; frame still open at release is ignored.
    @(negedge clk_i);
    drive_fab(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    send_beat(2'b00, 2'b11, 1'b0);
    send_beat(2'b00, 2'b11, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_ack", 32'(wb_ack), 32'd0);
    chk("midrst_dat", wb_dat_o, 32'd0);
    send_beat(2'b00, 2'b11, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    m_frames.delete();
    m_stall_max = 0;
    m_frozen = 1'b0;
    repeat (3) send_beat(2'b00, 2'b11, 1'b0);
    idle(3);
    send_frame(64, 1'b0, 1'b0);
    rd_chk(32'h04, 32'd1, "FRAMES_rst");
    rd_chk(32'h08, 32'd64, "LAST_rst");
`ifdef WRF_MON_GAP_EN
    rd_chk(32'h1C, 32'hFFFF_FFFF, "GAP_MIN_first");
    rd_chk(32'h18, 32'h0, "GAP_LAST_first");
`endif
    rd_chk(32'h20, 32'h0, "UNMAPPED");
    wr(32'h04, 32'hDEAD_BEEF);
    check_stats();
    wb_access(1'b0, 32'h00, 32'h0, d);
    chk("CTRL_end", d, 32'h0);
    chk("beats_end", 32'(src_beats), 32'(snk_beats));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
